// File: rtl/opcodes.sv
// RV64I major opcode constants shared by the control FSM and its bench.
package opcodes;
  localparam logic [6:0] TYPE_R    = 7'b0110011;
  localparam logic [6:0] IMM_ARITH = 7'b0010011;
  localparam logic [6:0] LD        = 7'b0000011;
  localparam logic [6:0] TYPE_S    = 7'b0100011;
  localparam logic [6:0] TYPE_SB   = 7'b1100011;
  localparam logic [6:0] TYPE_U    = 7'b0110111;
  localparam logic [6:0] TYPE_UJ   = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV64I core: fetch, decode, execute, memory
// and writeback sequencing, instruction register, illegal-opcode trap and
// retired-instruction counter. Datapath controls are decoded combinationally
// from the registered state and instruction register.
module multicycle_ctrl
  import opcodes::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic        i_imem_ready,
  input  logic        i_dmem_ready,
  input  logic        i_branch_taken,
  output logic        o_imem_req,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_ir,
  output logic [1:0]  o_alu_src_a,
  output logic        o_alu_src_b,
  output logic [1:0]  o_alu_op,
  output logic        o_pc_write,
  output logic [1:0]  o_pc_src,
  output logic        o_reg_write,
  output logic [1:0]  o_wb_sel,
  output logic        o_illegal,
  output logic [2:0]  o_state,
  output logic [63:0] o_retired
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  state_t     state;
  logic [6:0] opc;

  assign opc     = o_ir[6:0];
  assign o_state = state;

  // Opcodes this controller knows how to sequence; anything else traps.
  function automatic logic is_supported(input logic [6:0] op);
    case (op)
      TYPE_R, IMM_ARITH, LD, TYPE_S, TYPE_SB, TYPE_U, TYPE_UJ, JALR:
        is_supported = 1'b1;
      default:
        is_supported = 1'b0;
    endcase
  endfunction

  // State register, instruction latch and sticky illegal flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= FETCH;
      o_ir      <= 32'd0;
      o_illegal <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (i_imem_ready) begin
            o_ir  <= i_instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (is_supported(opc)) begin
            state <= EXECUTE;
          end else begin
            state     <= TRAP;
            o_illegal <= 1'b1;
          end
        end
        EXECUTE: begin
          if (opc == TYPE_SB) begin
            state <= FETCH;
          end else if (opc == LD || opc == TYPE_S) begin
            state <= MEM;
          end else begin
            state <= WRITEBACK;
          end
        end
        MEM: begin
          if (i_dmem_ready) begin
            state <= (opc == TYPE_S) ? FETCH : WRITEBACK;
          end
        end
        WRITEBACK: state <= FETCH;
        TRAP:      state <= TRAP;
        // Encodings 6 and 7 are unreachable; recover to a clean fetch.
        default:   state <= FETCH;
      endcase
    end
  end

  // Datapath controls; forced low while reset is asserted so requests
  // drop without waiting for a clock edge.
  always_comb begin
    o_imem_req  = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_alu_src_a = 2'd0;
    o_alu_src_b = 1'b0;
    o_alu_op    = 2'd0;
    o_pc_write  = 1'b0;
    o_pc_src    = 2'd0;
    o_reg_write = 1'b0;
    o_wb_sel    = 2'd0;
    if (!i_reset) begin
      case (state)
        FETCH: o_imem_req = 1'b1;
        EXECUTE: begin
          case (opc)
            TYPE_R: begin
              o_alu_op = 2'd2;
            end
            IMM_ARITH: begin
              o_alu_src_b = 1'b1;
              o_alu_op    = 2'd2;
            end
            LD, TYPE_S, JALR: begin
              o_alu_src_b = 1'b1;
            end
            TYPE_U: begin
              o_alu_src_a = 2'd2;
              o_alu_src_b = 1'b1;
            end
            TYPE_SB: begin
              o_alu_op   = 2'd1;
              o_pc_write = 1'b1;
              o_pc_src   = {1'b0, i_branch_taken};
            end
            default: ;
          endcase
        end
        MEM: begin
          o_dmem_req = 1'b1;
          o_dmem_we  = (opc == TYPE_S);
          // A store completes here; a load still needs writeback.
          if (i_dmem_ready && opc == TYPE_S) begin
            o_pc_write = 1'b1;
          end
        end
        WRITEBACK: begin
          o_reg_write = 1'b1;
          o_pc_write  = 1'b1;
          case (opc)
            LD: o_wb_sel = 2'd1;
            TYPE_UJ: begin
              o_wb_sel = 2'd2;
              o_pc_src = 2'd1;
            end
            JALR: begin
              o_wb_sel = 2'd2;
              o_pc_src = 2'd2;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Every PC update marks one retired instruction; wraps naturally.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_retired <= 64'd0;
    end else if (o_pc_write) begin
      o_retired <= o_retired + 64'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected output
// snapshot for each cycle, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        i_reset, i_imem_ready, i_dmem_ready, i_branch_taken;
  logic [31:0] i_instr;
  logic        o_imem_req, o_dmem_req, o_dmem_we, o_alu_src_b;
  logic        o_pc_write, o_reg_write, o_illegal;
  logic [1:0]  o_alu_src_a, o_alu_op, o_pc_src, o_wb_sel;
  logic [2:0]  o_state;
  logic [31:0] o_ir;
  logic [63:0] o_retired;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .i_clk(clk), .i_reset(i_reset), .i_instr(i_instr),
    .i_imem_ready(i_imem_ready), .i_dmem_ready(i_dmem_ready),
    .i_branch_taken(i_branch_taken),
    .o_imem_req(o_imem_req), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_ir(o_ir), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
    .o_alu_op(o_alu_op), .o_pc_write(o_pc_write), .o_pc_src(o_pc_src),
    .o_reg_write(o_reg_write), .o_wb_sel(o_wb_sel), .o_illegal(o_illegal),
    .o_state(o_state), .o_retired(o_retired)
  );

  // ctl layout: {state, imem_req, dmem_req, dmem_we, src_a, src_b, alu_op,
  //              pc_write, pc_src, reg_write, wb_sel, illegal}
  typedef struct {
    string       nm;
    logic [17:0] ctl;
    logic [31:0] ir;
    logic [63:0] ret;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] ir_m  = 32'd0;
  logic [63:0] ret_m = 64'd0;
  logic        ill_m = 1'b0;

  // Monitor: one snapshot per cycle, sampled away from the active edge.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t        e;
      logic [17:0] act;
      e   = sbq.pop_front();
      act = {o_state, o_imem_req, o_dmem_req, o_dmem_we, o_alu_src_a,
             o_alu_src_b, o_alu_op, o_pc_write, o_pc_src, o_reg_write,
             o_wb_sel, o_illegal};
      tests = tests + 3;
      if (act !== e.ctl) begin
        fails = fails + 1;
        $display("FAIL %s ctl: got %b expected %b", e.nm, act, e.ctl);
      end
      if (o_ir !== e.ir) begin
        fails = fails + 1;
        $display("FAIL %s ir: got %h expected %h", e.nm, o_ir, e.ir);
      end
      if (o_retired !== e.ret) begin
        fails = fails + 1;
        $display("FAIL %s retired: got %0d expected %0d", e.nm, o_retired, e.ret);
      end
    end
  end

  task automatic cyc(input string nm, input logic [2:0] st,
                     input logic imem, input logic dmem, input logic we,
                     input logic [1:0] a, input logic b, input logic [1:0] op,
                     input logic pcw, input logic [1:0] pcs,
                     input logic rw, input logic [1:0] wb);
    exp_t e;
    e.nm  = nm;
    e.ctl = {st, imem, dmem, we, a, b, op, pcw, pcs, rw, wb, ill_m};
    e.ir  = ir_m;
    e.ret = ret_m;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (pcw && !i_reset) ret_m = ret_m + 64'd1;
  endtask

  task automatic fetch(input string nm, input logic [31:0] instr);
    i_instr      = instr;
    i_imem_ready = 1'b1;
    cyc({nm, "_fetch"}, 3'd0, 1, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0);
    i_imem_ready = 1'b0;
    i_instr      = 32'hDEAD_BEEF;
    ir_m         = instr;
  endtask

  task automatic decode(input string nm);
    cyc({nm, "_decode"}, 3'd1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0);
  endtask

  task automatic exec(input string nm, input logic [1:0] a, input logic b,
                      input logic [1:0] op, input logic pcw, input logic [1:0] pcs);
    cyc({nm, "_exec"}, 3'd2, 0, 0, 0, a, b, op, pcw, pcs, 0, 2'd0);
  endtask

  task automatic mem(input string nm, input logic we, input logic rdy);
    i_dmem_ready = rdy;
    cyc({nm, "_mem"}, 3'd3, 0, 1, we, 2'd0, 0, 2'd0, we & rdy, 2'd0, 0, 2'd0);
    i_dmem_ready = 1'b0;
  endtask

  task automatic wback(input string nm, input logic [1:0] wb, input logic [1:0] pcs);
    cyc({nm, "_wb"}, 3'd4, 0, 0, 0, 2'd0, 0, 2'd0, 1, pcs, 1, wb);
  endtask

  task automatic in_reset(input string nm);
    i_reset = 1'b1;
    ir_m    = 32'd0;
    ret_m   = 64'd0;
    ill_m   = 1'b0;
    cyc(nm, 3'd0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0);
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_imem_ready = 1'b0; i_dmem_ready = 1'b0;
    i_branch_taken = 1'b0; i_instr = 32'd0;
    @(posedge clk);
    #1;
    in_reset("reset");

    // addi x1, x0, 5
    fetch("addi", 32'h00500093); decode("addi");
    exec("addi", 2'd0, 1, 2'd2, 0, 2'd0); wback("addi", 2'd0, 2'd0);

    // load with three wait cycles
    fetch("ld", 32'h0000B103); decode("ld"); exec("ld", 2'd0, 1, 2'd0, 0, 2'd0);
    for (int i = 0; i < 3; i++) mem("ld_wait", 0, 0);
    mem("ld", 0, 1); wback("ld", 2'd1, 2'd0);

    // branch taken, then not taken; a stray dmem ready must be ignored
    fetch("beq_t", 32'h00208463); i_dmem_ready = 1'b1; decode("beq_t");
    i_dmem_ready = 1'b0; i_branch_taken = 1'b1;
    exec("beq_t", 2'd0, 0, 2'd1, 1, 2'd1); i_branch_taken = 1'b0;
    fetch("beq_n", 32'h00208463); decode("beq_n");
    exec("beq_n", 2'd0, 0, 2'd1, 1, 2'd0);

    // jal and jalr
    fetch("jal", 32'h008000EF); decode("jal");
    exec("jal", 2'd0, 0, 2'd0, 0, 2'd0); wback("jal", 2'd2, 2'd1);
    fetch("jalr", 32'h000080E7); decode("jalr");
    exec("jalr", 2'd0, 1, 2'd0, 0, 2'd0); wback("jalr", 2'd2, 2'd2);

    // lui and a zero-wait store
    fetch("lui", 32'h000000B7); decode("lui");
    exec("lui", 2'd2, 1, 2'd0, 0, 2'd0); wback("lui", 2'd0, 2'd0);
    fetch("sd", 32'h0020B023); decode("sd");
    exec("sd", 2'd0, 1, 2'd0, 0, 2'd0); mem("sd", 1, 1);

    // unsupported opcode traps and stays trapped
    fetch("ill", 32'h0000007F); decode("ill"); ill_m = 1'b1;
    i_imem_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc("trap", 3'd5, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0);
    i_imem_ready = 1'b0;
    in_reset("trap_reset");

    // store interrupted by reset while waiting in MEM
    fetch("sd_rst", 32'h0020B023); decode("sd_rst");
    exec("sd_rst", 2'd0, 1, 2'd0, 0, 2'd0); mem("sd_rst", 1, 0);
    i_dmem_ready = 1'b1;
    in_reset("mem_reset");
    i_dmem_ready = 1'b0;

    // add x3, x1, x2 after recovery
    fetch("add", 32'h002081B3); decode("add");
    exec("add", 2'd0, 0, 2'd2, 0, 2'd0); wback("add", 2'd0, 2'd0);
    cyc("idle", 3'd0, 1, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
